mux_load_piso: RTL and testbench
================================

Name: mux_load_piso

Overview:
- Parallel-in/serial-out loader that sits directly upstream of the mux-input flop column (D0/D1/SD/SP style cells).
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock.
- Its SO/SO_VALID/SO_READY behaviour maps onto the downstream cell's data-select and clock-enable semantics:
  - SD = load select
  - SP = hold when not ready
- Exposes the internal load-select and enable strobes so the downstream column can be driven in lockstep.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = DIN[WIDTH-1] shifted out first; 0 = DIN[0] first.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- CD  input  1  reset; synchronous and active-high.
- DIN  input  WIDTH  parallel load word.
- LD_VALID  input  1  upstream has a word on DIN.
- LD_READY  output  1  block can accept DIN this cycle.
- SO  output  1  current serial bit.
- SO_VALID  output  1  SO holds a valid bit.
- SO_LAST  output  1  SO is the final bit of the word.
- SO_READY  input  1  downstream consumes SO this cycle (acts as SP).
- SD_O  output  1  registered copy of load-accept strobe (1 in the cycle after a load).
- SP_O  output  1  shift enable = SO_VALID & SO_READY (combinational).

Behaviour:
- Two states: IDLE, SHIFT.
- Internal shift register SR[WIDTH-1:0] and down-counter CNT, width clog2(WIDTH).
- Reset (CD=1 at CK edge, overrides everything):
  - state=IDLE, SR=0, CNT=0
  - SO=0, SO_VALID=0, SO_LAST=0, SD_O=0
  - After release, LD_READY=1 combinationally.
- LD_READY = (state==IDLE) | (state==SHIFT & CNT==0 & SO_READY). Combinational; enables zero-bubble back-to-back words.
- Load = LD_VALID & LD_READY at CK edge:
  - SR<=DIN, CNT<=WIDTH-1, state<=SHIFT, SO_VALID<=1, SD_O<=1.
  - SO<=DIN[WIDTH-1] if MSB_FIRST, else DIN[0].
  - SO_LAST<=0.
- Latency: first bit valid on SO one cycle after the load edge.
- SHIFT, SO_READY=1, CNT>0:
  - SR shifts toward the output end (left if MSB_FIRST, right otherwise), zero-filled.
  - SO<=next bit, CNT<=CNT-1.
  - SO_LAST<=1 when new CNT==0.
- SHIFT, SO_READY=1, CNT==0 (last bit consumed):
  - If a load occurs in the same cycle, the new word is loaded as above. The state stays SHIFT and there is no idle cycle.
  - Otherwise state<=IDLE, SO_VALID<=0, SO_LAST<=0, SO<=0.
- SHIFT, SO_READY=0: all state and outputs hold. LD_READY=0 unless in IDLE.
- SD_O is 1 for exactly one cycle per accepted word; it is 0 otherwise.
- LD_VALID while LD_READY=0: ignored. DIN is not captured and no state changes.
- CD asserted mid-word: word is discarded and no partial SO_LAST is emitted. The next cycle is IDLE with SO_VALID=0.
- A word always produces exactly WIDTH SP_O pulses. SO_LAST coincides with the WIDTH-th pulse.

Test Plan:
- Reset check: CD=1 for 2 cycles -> SO=0, SO_VALID=0, SO_LAST=0, SD_O=0, LD_READY=1 after release.
- MSB_FIRST=1, WIDTH=8, load DIN=0xA5, SO_READY=1 continuously:
  - SO over 8 cycles = 1,0,1,0,0,1,0,1
  - SO_LAST=1 only on the 8th
  - SO_VALID drops the next cycle; LD_READY high again.
- Backpressure: load 0xA5, toggle SO_READY 1,0,0,1,... -> SO/CNT frozen while 0; the bit sequence is unchanged; exactly 8 SP_O pulses.
- Back-to-back: LD_VALID held with 0xF0 then 0x0F -> 16 consecutive valid bits 1111000000001111. SO_LAST pulses at bits 8 and 16; no gap cycle.
- MSB_FIRST=0, load 0x01 -> SO = 1,0,0,0,0,0,0,0.
- Busy/abort: LD_VALID with 0xFF during bit 3 of 0x00 -> ignored (LD_READY=0). Then CD=1 at bit 5 -> SO_VALID=0 next cycle, no SO_LAST. A subsequent load of 0x80 streams correctly.

Source files
------------

// File: rtl/mux_load_piso_if.sv
// -----------------------------------------------------------------------------
// mux_load_piso_if
//   Bundles the load handshake, the serial output handshake and the
//   lockstep strobes of the mux_load_piso loader.
//
//   DIN       parallel word offered by the upstream source
//   LD_VALID  upstream has a word on DIN
//   LD_READY  loader can accept DIN this cycle
//   SO        current serial bit
//   SO_VALID  SO holds a valid bit
//   SO_LAST   SO is the final bit of the word
//   SO_READY  downstream consumes SO this cycle (hold when low)
//   SD_O      registered load-accept strobe (load select of the column)
//   SP_O      shift enable, SO_VALID & SO_READY
//
//   master : the upstream/downstream environment
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface mux_load_piso_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DIN;
  logic             LD_VALID;
  logic             LD_READY;
  logic             SO;
  logic             SO_VALID;
  logic             SO_LAST;
  logic             SO_READY;
  logic             SD_O;
  logic             SP_O;

  modport master (
    output DIN, LD_VALID, SO_READY,
    input  LD_READY, SO, SO_VALID, SO_LAST, SD_O, SP_O
  );

  modport slave (
    input  DIN, LD_VALID, SO_READY,
    output LD_READY, SO, SO_VALID, SO_LAST, SD_O, SP_O
  );
endinterface

// File: rtl/mux_load_piso.sv
// -----------------------------------------------------------------------------
// mux_load_piso
//   Parallel-in/serial-out loader feeding a mux-input flop column. A WIDTH-bit
//   word is accepted over LD_VALID/LD_READY and shifted out one bit per cycle
//   in which the downstream asserts SO_READY. The last bit of a word can be
//   consumed in the same cycle the next word is loaded, so back-to-back words
//   stream without a bubble.
//
//   Parameters
//     WIDTH      word length, 2..32
//     MSB_FIRST  1: DIN[WIDTH-1] leaves first, 0: DIN[0] leaves first
//
//   Ports
//     CK   clock, rising edge
//     CD   synchronous active-high reset, overrides everything
//     bus  mux_load_piso_if slave modport (see interface header)
// -----------------------------------------------------------------------------
module mux_load_piso #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CK,
  input  logic             CD,
  mux_load_piso_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [WIDTH-1:0] sr_q,       sr_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             so_q,       so_d;
  logic             so_valid_q, so_valid_d;
  logic             so_last_q,  so_last_d;
  logic             sd_q,       sd_d;

  logic ld_ready;
  logic load;
  logic [WIDTH-1:0] sr_shifted;
  logic             load_bit;

  // The last bit leaving in this cycle frees the register for a new word.
  assign ld_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_SHIFT) && (cnt_q == '0) && bus.SO_READY);
  assign load     = bus.LD_VALID && ld_ready;

  // Output end is the MSB when MSB_FIRST, else the LSB; vacated bits fill 0.
  assign sr_shifted = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
  assign load_bit   = MSB_FIRST ? bus.DIN[WIDTH-1] : bus.DIN[0];

  always_comb begin
    // NOTE: every next-state signal is defaulted to its held value first so
    // no path through the branches below leaves it unassigned (no latches).
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    so_d       = so_q;
    so_valid_d = so_valid_q;
    so_last_d  = so_last_q;
    sd_d       = load;

    if (load) begin
      state_d    = ST_SHIFT;
      sr_d       = bus.DIN;
      cnt_d      = CNT_MAX;
      so_d       = load_bit;
      so_valid_d = 1'b1;
      so_last_d  = 1'b0;
    end else if ((state_q == ST_SHIFT) && bus.SO_READY) begin
      if (cnt_q != '0) begin
        sr_d      = sr_shifted;
        so_d      = MSB_FIRST ? sr_shifted[WIDTH-1] : sr_shifted[0];
        cnt_d     = cnt_q - CW'(1);
        so_last_d = (cnt_q == CW'(1));
      end else begin
        state_d    = ST_IDLE;
        so_valid_d = 1'b0;
        so_last_d  = 1'b0;
        so_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge CK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (CD) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
      sd_q       <= sd_d;
    end
  end

  assign bus.LD_READY = ld_ready;
  assign bus.SO       = so_q;
  assign bus.SO_VALID = so_valid_q;
  assign bus.SO_LAST  = so_last_q;
  assign bus.SD_O     = sd_q;
  assign bus.SP_O     = so_valid_q && bus.SO_READY;

endmodule

// File: tb/tb_mux_load_piso.sv
// -----------------------------------------------------------------------------
// tb_mux_load_piso
//   Two loaders (MSB-first and LSB-first) share one stimulus stream. A
//   reference model keeps the not-yet-consumed bits of each DUT as a queue:
//   a load appends the word's bits in output order, a consumed bit is popped.
//   Every cycle both DUTs are compared against it; a table and a few
//   hand-written sequences add absolute expectations.
// -----------------------------------------------------------------------------
module tb_mux_load_piso;

  localparam int W = 8;

  logic CK = 1'b0;
  logic CD;
  always #5 CK = ~CK;

  mux_load_piso_if #(.WIDTH(W)) bm ();
  mux_load_piso_if #(.WIDTH(W)) bl ();

  assign bl.DIN      = bm.DIN;
  assign bl.LD_VALID = bm.LD_VALID;
  assign bl.SO_READY = bm.SO_READY;

  mux_load_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.CK(CK), .CD(CD), .bus(bm));
  mux_load_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.CK(CK), .CD(CD), .bus(bl));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending bits in the order they will appear on SO.
  bit q_m[$];
  bit q_l[$];
  bit sd_exp  = 1'b0;
  bit mdl_on  = 1'b0;

  typedef struct {
    bit         cd;
    bit         ldv;
    logic [7:0] din;
    bit         rdy;
    bit         so, v, last, ldr, sd;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit v, ldr;
    v   = (q_m.size() > 0);
    ldr = (q_m.size() == 0) || ((q_m.size() == 1) && bm.SO_READY);
    check("m.SO_VALID", bm.SO_VALID, v);
    check("m.SO",       bm.SO,       v ? q_m[0] : 1'b0);
    check("m.SO_LAST",  bm.SO_LAST,  q_m.size() == 1);
    check("m.LD_READY", bm.LD_READY, ldr);
    check("m.SD_O",     bm.SD_O,     sd_exp);
    check("m.SP_O",     bm.SP_O,     v && bm.SO_READY);
    check("l.SO_VALID", bl.SO_VALID, v);
    check("l.SO",       bl.SO,       v ? q_l[0] : 1'b0);
    check("l.SO_LAST",  bl.SO_LAST,  q_l.size() == 1);
    check("l.LD_READY", bl.LD_READY, ldr);
    check("l.SD_O",     bl.SD_O,     sd_exp);
    check("l.SP_O",     bl.SP_O,     v && bl.SO_READY);
  endtask

  task automatic model_update();
    bit ldr, ld;
    if (CD) begin
      q_m.delete();
      q_l.delete();
      sd_exp = 1'b0;
    end else begin
      ldr = (q_m.size() == 0) || ((q_m.size() == 1) && bm.SO_READY);
      ld  = bm.LD_VALID && ldr;
      if ((q_m.size() > 0) && bm.SO_READY) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (ld) begin
        for (int i = W - 1; i >= 0; i--) q_m.push_back(bm.DIN[i]);
        for (int i = 0; i < W; i++)      q_l.push_back(bm.DIN[i]);
      end
      sd_exp = ld;
    end
  endtask

  // Apply inputs at the falling edge, then compare once they have settled.
  task automatic drive(input bit cd, input bit ldv, input logic [W-1:0] din, input bit rdy);
    @(negedge CK);
    CD          = cd;
    bm.LD_VALID = ldv;
    bm.DIN      = din;
    bm.SO_READY = rdy;
    #1;
    if (mdl_on) model_check();
  endtask

  task automatic tick();
    @(posedge CK);
    model_update();
    mdl_on = 1'b1;
  endtask

  task automatic cyc(input bit cd, input bit ldv, input logic [W-1:0] din, input bit rdy);
    drive(cd, ldv, din, rdy);
    tick();
  endtask

  // Streams out the word currently held, SO_READY following a 1,0,0,1 pattern
  // when bp is set. Bits are reassembled into the original DIN of each DUT.
  task automatic collect8(input bit bp, output int np, output logic [7:0] am,
                          output logic [7:0] al, output int nlast);
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit rdy;
    np = 0; nlast = 0; am = '0; al = '0;
    for (int k = 0; k < 40; k++) begin
      rdy = bp ? pat[k % 4] : 1'b1;
      drive(1'b0, 1'b0, '0, rdy);
      if (bm.SP_O) begin
        np++;
        am = {am[6:0], bm.SO};
        if (bm.SO_LAST) nlast++;
      end
      if (bl.SP_O) al = {bl.SO, al[7:1]};
      tick();
      if (!bm.SO_VALID && !bl.SO_VALID) break;
    end
  endtask

  function automatic vec_t mk(input bit cd, input bit ldv, input logic [7:0] din, input bit rdy,
                              input bit so, input bit v, input bit last, input bit ldr, input bit sd);
    vec_t r;
    r.cd = cd; r.ldv = ldv; r.din = din; r.rdy = rdy;
    r.so = so; r.v = v; r.last = last; r.ldr = ldr; r.sd = sd;
    return r;
  endfunction

  initial begin
    int np, nlast, nbits, gaps, widx;
    logic [7:0]  am, al;
    logic [15:0] bits, lastmask;
    bit acc, ldv;
    logic [7:0] din;

    CD = 1'b1; bm.LD_VALID = 1'b0; bm.DIN = '0; bm.SO_READY = 1'b0;

    // Reset held for two cycles; the second is already checked against the
    // model's empty state.
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);

    // 0xA5 MSB-first with SO_READY high: absolute expectations for dut_m.
    tbl[0]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 1, 8'hA5, 1, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[3]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 8'h00, 1, 1, 1, 1, 1, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].cd, tbl[i].ldv, tbl[i].din, tbl[i].rdy);
      check($sformatf("tbl%0d.SO", i),       bm.SO,       tbl[i].so);
      check($sformatf("tbl%0d.SO_VALID", i), bm.SO_VALID, tbl[i].v);
      check($sformatf("tbl%0d.SO_LAST", i),  bm.SO_LAST,  tbl[i].last);
      check($sformatf("tbl%0d.LD_READY", i), bm.LD_READY, tbl[i].ldr);
      check($sformatf("tbl%0d.SD_O", i),     bm.SD_O,     tbl[i].sd);
      tick();
    end

    // Backpressure: same bits, exactly 8 shift pulses, one SO_LAST.
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    collect8(1'b1, np, am, al, nlast);
    check("bp.pulses",  np,    8);
    check("bp.bits_m",  am,    8'hA5);
    check("bp.bits_l",  al,    8'hA5);
    check("bp.last",    nlast, 1);

    // Back-to-back 0xF0 then 0x0F with LD_VALID held: 16 gapless bits.
    bits = '0; lastmask = '0; nbits = 0; gaps = 0; widx = 0;
    for (int k = 0; k < 30 && nbits < 16; k++) begin
      ldv = (widx < 2);
      din = (widx == 0) ? 8'hF0 : 8'h0F;
      drive(1'b0, ldv, din, 1'b1);
      acc = ldv && bm.LD_READY;
      if (bm.SO_VALID) begin
        bits = {bits[14:0], bm.SO};
        if (bm.SO_LAST) lastmask[15 - nbits] = 1'b1;
        nbits++;
      end else if (nbits > 0) begin
        gaps++;
      end
      tick();
      if (acc) widx++;
    end
    check("b2b.nbits", nbits,    16);
    check("b2b.bits",  bits,     16'hF00F);
    check("b2b.last",  lastmask, 16'h0101);
    check("b2b.gaps",  gaps,     0);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // Busy then abort: 0x00 loaded, 0xFF offered at bit 3, reset at bit 5.
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 8'hFF, 1'b1);
    check("busy.LD_READY", bm.LD_READY, 1'b0);
    tick();
    cyc(1'b0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b1);
    check("abort.SO_LAST", bm.SO_LAST, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h80, 1'b1);
    check("abort.SO_VALID", bm.SO_VALID, 1'b0);
    check("abort.SO_LAST2", bm.SO_LAST,  1'b0);
    check("abort.LD_READY", bm.LD_READY, 1'b1);
    tick();
    collect8(1'b0, np, am, al, nlast);
    check("post.pulses", np,    8);
    check("post.bits_m", am,    8'h80);
    check("post.bits_l", al,    8'h80);
    check("post.last",   nlast, 1);

    // LSB-first lone bit: 0x01 leaves dut_l as 1 followed by seven zeros.
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("lsb.first", bl.SO, 1'b1);
    tick();
    for (int i = 1; i < W; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      check($sformatf("lsb.bit%0d", i), bl.SO, 1'b0);
      tick();
    end

    // Random traffic, occasional reset, against the model only.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
          W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
